load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one memory operation at a time, byte/half/word sizing with lane steering,
// misalignment and illegal-encoding checks, and a bounded wait for the memory acknowledge.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [1:0]  fsm_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the memory side completes on an edge where mem_req && mem_ack.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;

    logic        req_err;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [15:0] load_half;
    logic [7:0]  load_byte;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE);
    assign fsm_state = state;

    // Decode the offered request: lane enables, replicated store data, legality.
    always_comb begin
        req_err   = 1'b0;
        req_be    = 4'b0000;
        req_wdata = 32'd0;
        case (funct3)
            3'b000, 3'b100: req_be = 4'b0001 << addr[1:0];
            3'b001, 3'b101: begin
                req_be  = 4'b0011 << {addr[1], 1'b0};
                req_err = addr[0];
            end
            3'b010: begin
                req_be  = 4'b1111;
                req_err = |addr[1:0];
            end
            default: req_err = 1'b1;
        endcase
        if (is_store && funct3[2]) begin
            req_err = 1'b1;
        end
        if (is_store) begin
            case (funct3[1:0])
                2'b00:   req_wdata = {4{wdata[7:0]}};
                2'b01:   req_wdata = {2{wdata[15:0]}};
                default: req_wdata = wdata;
            endcase
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        load_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_byte = lat_off[0] ? load_half[15:8] : load_half[7:0];
        case (lat_funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            lat_funct3 <= 3'd0;
            lat_off    <= 2'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_funct3 <= funct3;
                        lat_off    <= addr[1:0];
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'd0;
                        end else begin
                            state     <= WAIT;
                            wait_cnt  <= 8'd1;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= req_be;
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                WAIT: begin
                    // An acknowledge on the final allowed cycle still counts as success.
                    if (mem_ack || (wait_cnt == TIMEOUT_LIMIT)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= ~mem_ack;
                        resp_data  <= (mem_ack && !mem_we) ? load_data : 32'd0;
                        wait_cnt   <= 8'd0;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= 32'd0;
                        mem_be     <= 4'd0;
                        mem_wdata  <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_data  <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
